// File: rtl/spi_master_param_pkg.sv
// Shared definitions for the parametrised SPI master.
// Contents: FSM state encoding, the four SPI mode codes packed as
// {cpol, cpha}, and helpers that unpack a latched mode word.
package spi_master_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Mode codes are {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic mode_cpol(input logic [1:0] m);
    return (m == MODE2) || (m == MODE3);
  endfunction

  function automatic logic mode_cpha(input logic [1:0] m);
    return (m == MODE1) || (m == MODE3);
  endfunction

endpackage

// File: rtl/spi_master_param_clk_tick.sv
// Half-period tick generator for the SPI master.
// Ports:
//   clk      system clock
//   RST      asynchronous active-high reset
//   clear_i  restarts the count (asserted on frame accept)
//   tick_o   one-cycle pulse every CLK_DIV clock cycles after a clear
module spi_master_param_clk_tick
  import spi_master_param_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic RST,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count 0..CLK_DIV-1 and wrap; a clear forces the first tick of a
  // frame to land exactly CLK_DIV cycles after the accept edge.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master (modes 0-3, NUM_CS selects).
// Ports:
//   clk, RST            clock, asynchronous active-high reset
//   tx_valid/tx_ready   one-word handshake; tx_ready only in IDLE
//   tx_data, tx_cs_sel  word and chip-select index, sampled at accept
//   cpol, cpha          SPI mode, sampled at accept
//   spi_cs              active-low chip selects
//   spi_clk, spi_data   SCLK and MOSI
//   spi_miso            MISO
//   rx_data, rx_valid   received word and its one-cycle strobe
//   busy                inverse of tx_ready
module spi_master_param
  import spi_master_param_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter int NUM_CS    = 1,
  parameter int CS_SETUP  = 1,
  parameter int CS_HOLD   = 1,
  parameter int LSB_FIRST = 0,
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   tx_cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  output logic [NUM_CS-1:0] spi_cs,
  output logic              spi_clk,
  output logic              spi_data,
  input  logic              spi_miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int BIT_W   = $clog2(2 * DATA_W + 1);
  localparam int DLY_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam logic [BIT_W-1:0] LAST_EDGE  = BIT_W'(2 * DATA_W);
  localparam logic [DLY_W-1:0] SETUP_LAST = DLY_W'(CS_SETUP - 1);
  localparam logic [DLY_W-1:0] HOLD_LAST  = DLY_W'(CS_HOLD);

  state_e              state_q, state_d;
  logic [BIT_W-1:0]    edge_q, edge_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   txsh_q, txsh_d;
  logic [DATA_W-1:0]   rxsh_q, rxsh_d;
  logic [DATA_W-1:0]   rxdata_q, rxdata_d;
  logic                rxvalid_q, rxvalid_d;
  logic [NUM_CS-1:0]   cs_q, cs_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_CS-1:0]   cs_sel_mask;
  logic [BIT_W-1:0]    cur_k;
  logic                edge_go;
  logic                accept;
  logic                tick;

  assign tx_ready = (state_q == ST_IDLE);
  assign busy     = ~tx_ready;
  assign accept   = tx_valid && tx_ready;

  spi_master_param_clk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .RST     (RST),
    .clear_i (accept),
    .tick_o  (tick)
  );

  // An out-of-range index matches no bit, so the frame runs deselected.
  always_comb begin
    cs_sel_mask = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (tx_cs_sel == CS_W'(i)) begin
        cs_sel_mask[i] = 1'b0;
      end
    end
  end

  // Next-state logic. The tick that ends SETUP is also SCLK edge 1, and
  // HOLD waits CS_HOLD+1 ticks so CS rises one extra half-period after
  // the last edge. Edge actions are shared between SETUP and SHIFT.
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    dly_d     = dly_q;
    mode_d    = mode_q;
    txsh_d    = txsh_q;
    rxsh_d    = rxsh_q;
    rxdata_d  = rxdata_q;
    rxvalid_d = 1'b0;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    edge_go   = 1'b0;
    cur_k     = edge_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d = ST_SETUP;
          dly_d   = '0;
          edge_d  = '0;
          mode_d  = {cpol, cpha};
          sclk_d  = cpol;
          txsh_d  = tx_data;
          mosi_d  = (LSB_FIRST != 0) ? tx_data[0] : tx_data[DATA_W-1];
          cs_d    = cs_sel_mask;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          if (dly_q == SETUP_LAST) begin
            state_d = ST_SHIFT;
            cur_k   = BIT_W'(1);
            edge_go = 1'b1;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          edge_go = 1'b1;
          if (cur_k == LAST_EDGE) begin
            state_d = ST_HOLD;
            dly_d   = '0;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (dly_q == HOLD_LAST) begin
            state_d   = ST_IDLE;
            cs_d      = '1;
            rxdata_d  = rxsh_q;
            rxvalid_d = 1'b1;
            sclk_d    = mode_cpol(mode_q);
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Odd edges are leading. cpha=0 samples on leading and shifts on
    // trailing; cpha=1 does the reverse, skipping edge 1 because the
    // first bit is already on the line from accept.
    if (edge_go) begin
      edge_d = cur_k;
      sclk_d = ~sclk_q;
      if (mode_cpha(mode_q) ? ~cur_k[0] : cur_k[0]) begin
        rxsh_d = (LSB_FIRST != 0) ? {spi_miso, rxsh_q[DATA_W-1:1]}
                                  : {rxsh_q[DATA_W-2:0], spi_miso};
      end
      if (mode_cpha(mode_q) ? (cur_k[0] && (cur_k != BIT_W'(1)))
                            : (!cur_k[0] && (cur_k != LAST_EDGE))) begin
        if (LSB_FIRST != 0) begin
          txsh_d = txsh_q >> 1;
          mosi_d = txsh_q[1];
        end else begin
          txsh_d = txsh_q << 1;
          mosi_d = txsh_q[DATA_W-2];
        end
      end
    end
  end

  // State and datapath registers; reset drops any frame in flight.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      edge_q    <= '0;
      dly_q     <= '0;
      mode_q    <= MODE0;
      txsh_q    <= '0;
      rxsh_q    <= '0;
      rxdata_q  <= '0;
      rxvalid_q <= 1'b0;
      cs_q      <= '1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      dly_q     <= dly_d;
      mode_q    <= mode_d;
      txsh_q    <= txsh_d;
      rxsh_q    <= rxsh_d;
      rxdata_q  <= rxdata_d;
      rxvalid_q <= rxvalid_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
    end
  end

  assign spi_cs   = cs_q;
  assign spi_clk  = sclk_q;
  assign spi_data = mosi_q;
  assign rx_data  = rxdata_q;
  assign rx_valid = rxvalid_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: three instances cover the
// 8-bit/4-CS default timing, a 16-bit LSB-first build, and a 5-CS
// build with an out-of-range select.
module tb_spi_master_param;
  import spi_master_param_pkg::*;

  logic clk = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic       txValidA, txReadyA, cpolA, cphaA, spiClkA, spiDataA, spiMisoA, rxValidA, busyA;
  logic [7:0] txDataA, rxDataA;
  logic [1:0] txCsSelA;
  logic [3:0] spiCsA;

  logic        txValidB, txReadyB, cpolB, cphaB, spiClkB, spiDataB, spiMisoB, rxValidB, busyB;
  logic [15:0] txDataB, rxDataB;
  logic [0:0]  txCsSelB, spiCsB;

  logic       txValidC, txReadyC, cpolC, cphaC, spiClkC, spiDataC, spiMisoC, rxValidC, busyC;
  logic [7:0] txDataC, rxDataC;
  logic [2:0] txCsSelC;
  logic [4:0] spiCsC;

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(4), .CS_SETUP(1), .CS_HOLD(1), .LSB_FIRST(0)) dutA (
    .clk(clk), .RST(RST), .tx_valid(txValidA), .tx_ready(txReadyA), .tx_data(txDataA),
    .tx_cs_sel(txCsSelA), .cpol(cpolA), .cpha(cphaA), .spi_cs(spiCsA), .spi_clk(spiClkA),
    .spi_data(spiDataA), .spi_miso(spiMisoA), .rx_data(rxDataA), .rx_valid(rxValidA), .busy(busyA));

  spi_master_param #(.DATA_W(16), .CLK_DIV(4), .NUM_CS(1), .CS_SETUP(1), .CS_HOLD(1), .LSB_FIRST(1)) dutB (
    .clk(clk), .RST(RST), .tx_valid(txValidB), .tx_ready(txReadyB), .tx_data(txDataB),
    .tx_cs_sel(txCsSelB), .cpol(cpolB), .cpha(cphaB), .spi_cs(spiCsB), .spi_clk(spiClkB),
    .spi_data(spiDataB), .spi_miso(spiMisoB), .rx_data(rxDataB), .rx_valid(rxValidB), .busy(busyB));

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(5), .CS_SETUP(1), .CS_HOLD(1), .LSB_FIRST(0)) dutC (
    .clk(clk), .RST(RST), .tx_valid(txValidC), .tx_ready(txReadyC), .tx_data(txDataC),
    .tx_cs_sel(txCsSelC), .cpol(cpolC), .cpha(cphaC), .spi_cs(spiCsC), .spi_clk(spiClkC),
    .spi_data(spiDataC), .spi_miso(spiMisoC), .rx_data(rxDataC), .rx_valid(rxValidC), .busy(busyC));

  assign spiMisoB = spiDataB;
  assign spiMisoC = spiDataC;

  // Mode-aware slave on dutA/CS0: counts SCLK edges while selected and
  // presents slaveWord MSB-first, changing bits on the non-sampling edge.
  logic       slaveEn, slCpha, slPrevClk, slPrevCs;
  logic [7:0] slaveWord;
  int         slEdges, slN;

  always @(posedge clk or posedge RST) begin
    if (RST) begin
      slPrevClk <= 1'b0;
      slPrevCs  <= 1'b1;
      slEdges   <= 0;
    end else begin
      slPrevClk <= spiClkA;
      slPrevCs  <= spiCsA[0];
      if (spiCsA[0]) slEdges <= 0;
      else if (!slPrevCs && (spiClkA !== slPrevClk)) slEdges <= slEdges + 1;
    end
  end

  always_comb begin
    slN = (slEdges > int'(slCpha)) ? (slEdges - int'(slCpha)) / 2 : 0;
    if (slN > 7) slN = 7;
  end

  assign spiMisoA = slaveEn ? slaveWord[7 - slN] : spiDataA;

  // Per-cycle history of the instance under test; index 0 is the accept cycle.
  logic       histClk [0:159];
  logic [4:0] histCs  [0:159];
  logic       histMosi[0:159];
  logic       histRxv [0:159];
  logic       histRdy [0:159];

  task automatic record_a(input int c);
    histClk[c] = spiClkA; histCs[c] = {1'b1, spiCsA}; histMosi[c] = spiDataA;
    histRxv[c] = rxValidA; histRdy[c] = txReadyA;
  endtask

  task automatic record_b(input int c);
    histClk[c] = spiClkB; histCs[c] = {4'hF, spiCsB}; histMosi[c] = spiDataB;
    histRxv[c] = rxValidB; histRdy[c] = txReadyB;
  endtask

  task automatic record_c(input int c);
    histClk[c] = spiClkC; histCs[c] = spiCsC; histMosi[c] = spiDataC;
    histRxv[c] = rxValidC; histRdy[c] = txReadyC;
  endtask

  // Called at a negedge with txValid already raised; cycle c is sampled
  // at the negedge following the c-th rising edge.
  task automatic capture_a(input int n, input bit hold);
    record_a(0);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) txValidA = 1'b0;
      record_a(c);
    end
  endtask

  task automatic capture_b(input int n);
    record_b(0);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) txValidB = 1'b0;
      record_b(c);
    end
  endtask

  task automatic capture_c(input int n);
    record_c(0);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) txValidC = 1'b0;
      record_c(c);
    end
  endtask

  // First cycle with an unexpected SCLK edge, -1 if edges are missing, 0 if all fit.
  function automatic int edge_err(input int n, input int first, input int step, input int nexp);
    int k = 0;
    for (int c = 2; c <= n; c++) begin
      if (histClk[c] !== histClk[c-1]) begin
        if (k >= nexp || c != first + step * k) return c;
        k++;
      end
    end
    return (k == nexp) ? 0 : -1;
  endfunction

  function automatic int rxv_count(input int lo, input int hi);
    int cnt = 0;
    for (int c = lo; c <= hi; c++) if (histRxv[c] === 1'b1) cnt++;
    return cnt;
  endfunction

  function automatic int rdy_count(input int lo, input int hi);
    int cnt = 0;
    for (int c = lo; c <= hi; c++) if (histRdy[c] !== 1'b0) cnt++;
    return cnt;
  endfunction

  // First cycle where CS differs from lowVal inside [fallC,riseC) or from all-high outside.
  function automatic int cs_err(input int n, input logic [4:0] lowVal, input int fallC, input int riseC);
    for (int c = 0; c <= n; c++) begin
      if (histCs[c] !== ((c >= fallC && c < riseC) ? lowVal : 5'h1F)) return (c == 0) ? 999 : c;
    end
    return 0;
  endfunction

  // MOSI value seen at each odd (leading) edge cycle, assembled MSB-first.
  function automatic logic [7:0] mosi_word8();
    logic [7:0] w;
    for (int j = 0; j < 8; j++) w[7-j] = histMosi[5 + 8*j];
    return w;
  endfunction

  function automatic logic [15:0] mosi_word16_lsb();
    logic [15:0] w;
    for (int j = 0; j < 16; j++) w[j] = histMosi[5 + 8*j];
    return w;
  endfunction

  // Reset values while RST is held, then tx_ready after release.
  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (spiCsA !== 4'hF) begin bad++; $display("[TB] FAIL reset_cs: got %h expected F", spiCsA); end
    total++; if (spiClkA !== 1'b0) begin bad++; $display("[TB] FAIL reset_sclk: got %b expected 0", spiClkA); end
    total++; if (spiDataA !== 1'b0) begin bad++; $display("[TB] FAIL reset_mosi: got %b expected 0", spiDataA); end
    total++; if (rxDataA !== 8'h00) begin bad++; $display("[TB] FAIL reset_rxdata: got %h expected 00", rxDataA); end
    total++; if (rxValidA !== 1'b0) begin bad++; $display("[TB] FAIL reset_rxvalid: got %b expected 0", rxValidA); end
    total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busyA); end
    RST = 1'b0;
    @(negedge clk);
    total++; if (txReadyA !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 1", txReadyA); end
  endtask

  // Mode 0, 8'hA5 looped back on CS0 with default timing.
  task automatic test_mode0_loopback();
    int r;
    slaveEn = 1'b0;
    @(negedge clk);
    txDataA = 8'hA5; txCsSelA = 2'd0; cpolA = 1'b0; cphaA = 1'b0; txValidA = 1'b1;
    capture_a(80, 1'b0);
    r = cs_err(80, 5'b11110, 1, 73);
    total++; if (r != 0) begin bad++; $display("[TB] FAIL m0_cs_timing: first bad cycle %0d expected none", r); end
    r = edge_err(80, 5, 4, 16);
    total++; if (r != 0) begin bad++; $display("[TB] FAIL m0_sclk_edges: first bad cycle %0d expected none", r); end
    total++; if (mosi_word8() !== 8'hA5) begin bad++; $display("[TB] FAIL m0_mosi_bits: got %h expected a5", mosi_word8()); end
    total++; if (histRxv[73] !== 1'b1 || rxv_count(1, 80) != 1) begin bad++; $display("[TB] FAIL m0_rx_valid: at73=%b count=%0d expected 1/1", histRxv[73], rxv_count(1, 80)); end
    total++; if (rxDataA !== 8'hA5) begin bad++; $display("[TB] FAIL m0_rx_data: got %h expected a5", rxDataA); end
    total++; if (rdy_count(1, 72) != 0 || histRdy[73] !== 1'b1) begin bad++; $display("[TB] FAIL m0_ready: high_in_frame=%0d at73=%b expected 0/1", rdy_count(1, 72), histRdy[73]); end
  endtask

  // Modes 1..3 against the slave returning 8'hC3 while 8'h3C is sent.
  task automatic test_modes();
    logic [1:0] modes [3];
    logic [1:0] md;
    int r;
    modes = '{MODE1, MODE2, MODE3};
    slaveEn = 1'b1; slaveWord = 8'hC3;
    for (int m = 0; m < 3; m++) begin
      md = modes[m];
      slCpha = md[0];
      @(negedge clk);
      txDataA = 8'h3C; txCsSelA = 2'd0; cpolA = md[1]; cphaA = md[0]; txValidA = 1'b1;
      capture_a(80, 1'b0);
      total++; if (rxDataA !== 8'hC3) begin bad++; $display("[TB] FAIL mode%0d_rx_data: got %h expected c3", m + 1, rxDataA); end
      total++; if (histClk[4] !== md[1] || histClk[80] !== md[1]) begin bad++; $display("[TB] FAIL mode%0d_sclk_idle: before=%b after=%b expected %b", m + 1, histClk[4], histClk[80], md[1]); end
      r = edge_err(80, 5, 4, 16);
      total++; if (r != 0) begin bad++; $display("[TB] FAIL mode%0d_sclk_edges: first bad cycle %0d expected none", m + 1, r); end
      total++; if (mosi_word8() !== 8'h3C) begin bad++; $display("[TB] FAIL mode%0d_mosi_bits: got %h expected 3c", m + 1, mosi_word8()); end
      total++; if (histRxv[73] !== 1'b1) begin bad++; $display("[TB] FAIL mode%0d_rx_valid: got %b expected 1", m + 1, histRxv[73]); end
    end
    slaveEn = 1'b0;
  endtask

  // 16-bit LSB-first frame of 16'h8001 on dutB.
  task automatic test_lsb16();
    int r;
    @(negedge clk);
    txDataB = 16'h8001; txCsSelB = 1'b0; cpolB = 1'b0; cphaB = 1'b0; txValidB = 1'b1;
    capture_b(140);
    total++; if (histMosi[1] !== 1'b1) begin bad++; $display("[TB] FAIL lsb_first_bit: got %b expected 1", histMosi[1]); end
    total++; if (mosi_word16_lsb() !== 16'h8001) begin bad++; $display("[TB] FAIL lsb_mosi_bits: got %h expected 8001", mosi_word16_lsb()); end
    total++; if (histMosi[140] !== 1'b1) begin bad++; $display("[TB] FAIL lsb_mosi_hold: got %b expected 1", histMosi[140]); end
    r = edge_err(140, 5, 4, 32);
    total++; if (r != 0) begin bad++; $display("[TB] FAIL lsb_sclk_edges: first bad cycle %0d expected none", r); end
    r = cs_err(140, 5'b11110, 1, 137);
    total++; if (r != 0) begin bad++; $display("[TB] FAIL lsb_cs_timing: first bad cycle %0d expected none", r); end
    total++; if (histRxv[137] !== 1'b1 || rxDataB !== 16'h8001) begin bad++; $display("[TB] FAIL lsb_rx: valid137=%b data=%h expected 1/8001", histRxv[137], rxDataB); end
  endtask

  // tx_valid held high on select 2: two frames separated by one CS-high cycle.
  task automatic test_back_to_back();
    int otherLow = 0;
    slaveEn = 1'b0;
    @(negedge clk);
    txDataA = 8'h96; txCsSelA = 2'd2; cpolA = 1'b0; cphaA = 1'b0; txValidA = 1'b1;
    capture_a(146, 1'b1);
    txValidA = 1'b0;
    for (int c = 0; c <= 146; c++) if ((histCs[c] | 5'b00100) !== 5'h1F) otherLow++;
    total++; if (otherLow != 0) begin bad++; $display("[TB] FAIL b2b_other_cs: low cycles %0d expected 0", otherLow); end
    total++; if (histCs[72] !== 5'b11011 || histCs[73] !== 5'h1F || histCs[74] !== 5'b11011 || histCs[146] !== 5'h1F) begin
      bad++; $display("[TB] FAIL b2b_cs_gap: c72=%h c73=%h c74=%h c146=%h expected 1b/1f/1b/1f", histCs[72], histCs[73], histCs[74], histCs[146]);
    end
    total++; if (rxv_count(1, 146) != 2 || histRxv[73] !== 1'b1 || histRxv[146] !== 1'b1) begin
      bad++; $display("[TB] FAIL b2b_rx_valid: count=%0d expected 2 at 73 and 146", rxv_count(1, 146));
    end
    total++; if (rdy_count(1, 145) != 1) begin bad++; $display("[TB] FAIL b2b_ready: high cycles %0d expected 1", rdy_count(1, 145)); end
    total++; if (rxDataA !== 8'h96) begin bad++; $display("[TB] FAIL b2b_rx_data: got %h expected 96", rxDataA); end
  endtask

  // Reset at cycle 30 of a frame, then a clean frame afterwards.
  task automatic test_reset_midframe();
    int pulses = 0;
    @(negedge clk);
    txDataA = 8'hA5; txCsSelA = 2'd0; cpolA = 1'b0; cphaA = 1'b0; txValidA = 1'b1;
    capture_a(29, 1'b0);
    @(negedge clk);
    RST = 1'b1;
    #1;
    total++; if (spiCsA !== 4'hF) begin bad++; $display("[TB] FAIL rst_mid_cs: got %h expected f", spiCsA); end
    total++; if (spiClkA !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_sclk: got %b expected 0", spiClkA); end
    total++; if (busyA !== 1'b0 || rxDataA !== 8'h00) begin bad++; $display("[TB] FAIL rst_mid_state: busy=%b rx=%h expected 0/00", busyA, rxDataA); end
    repeat (2) @(negedge clk);
    RST = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (rxValidA === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("[TB] FAIL rst_mid_no_rxvalid: pulses %0d expected 0", pulses); end
    txDataA = 8'h5B; txValidA = 1'b1;
    capture_a(80, 1'b0);
    total++; if (histRxv[73] !== 1'b1 || rxDataA !== 8'h5B) begin bad++; $display("[TB] FAIL rst_mid_recover: valid73=%b data=%h expected 1/5b", histRxv[73], rxDataA); end
  endtask

  // Out-of-range select on the 5-CS build.
  task automatic test_bad_sel();
    int r;
    @(negedge clk);
    txDataC = 8'h5A; txCsSelC = 3'd5; cpolC = 1'b0; cphaC = 1'b0; txValidC = 1'b1;
    capture_c(80);
    r = cs_err(80, 5'h1F, 1, 73);
    total++; if (r != 0) begin bad++; $display("[TB] FAIL badsel_cs: first low cycle %0d expected none", r); end
    total++; if (histRxv[73] !== 1'b1 || rxv_count(1, 80) != 1) begin bad++; $display("[TB] FAIL badsel_rx_valid: at73=%b count=%0d expected 1/1", histRxv[73], rxv_count(1, 80)); end
    total++; if (rxDataC !== 8'h5A || busyC !== 1'b0) begin bad++; $display("[TB] FAIL badsel_rx_data: data=%h busy=%b expected 5a/0", rxDataC, busyC); end
    total++; if (busyB !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy_b: got %b expected 0", busyB); end
  endtask

  // Sequence every scenario and print the summary.
  initial begin
    RST = 1'b1;
    txValidA = 1'b0; txDataA = '0; txCsSelA = '0; cpolA = 1'b0; cphaA = 1'b0;
    txValidB = 1'b0; txDataB = '0; txCsSelB = '0; cpolB = 1'b0; cphaB = 1'b0;
    txValidC = 1'b0; txDataC = '0; txCsSelC = '0; cpolC = 1'b0; cphaC = 1'b0;
    slaveEn = 1'b0; slCpha = 1'b0; slaveWord = 8'h00;
    test_reset();
    test_mode0_loopback();
    test_modes();
    test_lsb16();
    test_back_to_back();
    test_reset_midframe();
    test_bad_sel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
